ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage directly upstream of the decode stage. Holds the fetch PC and issues one-outstanding word requests to instruction memory over a req/ack handshake. Parks each returned word in a one-entry buffer, then presents it to decode as `ir`/`pc` with a one-cycle `ir_already` strobe. Handles decode-side stall and redirect (branch/jump flush), discarding in-flight words fetched from the old path.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset; low 2 bits must be 0.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  decode cannot accept a new instruction this cycle.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] forced to 0.
- `imem_req`  out  1  request valid (combinational from state/buffer/redirect).
- `imem_addr`  out  32  word address of request.
- `imem_ack`  in  1  response valid; may be high in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `ir`  out  32  instruction to decode (registered).
- `pc`  out  32  address of `ir` (registered).
- `ir_already`  out  1  `ir`/`pc` valid for exactly this cycle (registered).

## Operation
- Internal: `fetch_pc`, `req_addr`, buffer (`buf_valid`, `buf_ir`, `buf_pc`), state {FETCH, WAIT, DISCARD}.
- `deliver = buf_valid & !stall & !redirect`; `room = !buf_valid | deliver`.
- Delivery: on `deliver`, `ir<=buf_ir`, `pc<=buf_pc`, `ir_already<=1`, buffer cleared; otherwise `ir_already<=0`, `ir`/`pc` hold.
- FETCH: `imem_req = room & !redirect`, `imem_addr = fetch_pc`, `req_addr<=fetch_pc` on req. Req & ack: buffer loads {rdata, fetch_pc}, `fetch_pc += 4`, stay FETCH. Req & !ack: -> WAIT.
- WAIT: `imem_req=1`, `imem_addr=req_addr` (stable). Ack: buffer loads, `fetch_pc += 4`, -> FETCH.
- DISCARD: `imem_req=1`, `imem_addr=req_addr`. Ack: data dropped, -> FETCH.
- Request is raised only when `room`; once raised it is held, address unchanged, until ack. Buffer is therefore always free or draining when ack arrives; no overflow path.
- Redirect (priority over everything): `fetch_pc <= {redirect_pc[31:2],2'b00}`, `buf_valid<=0`, `ir_already<=0`. In FETCH no request that cycle. In WAIT without ack -> DISCARD; in WAIT with ack, data dropped, -> FETCH. In DISCARD stays DISCARD until ack.
- Stall blocks delivery only; a fetch into an empty buffer still proceeds under stall.
- `fetch_pc` wraps 0xFFFF_FFFC -> 0x0000_0000 silently.

## Timing
- Reset values: `ir=0`, `pc=0`, `ir_already=0`, `fetch_pc=RESET_PC`, `buf_valid=0`, state FETCH; `imem_req=0` while `reset` high.
- Reset mid-transaction: all state returns to reset values next cycle; memory side is reset by the same `reset`.
- First request in the first cycle after `reset` drops.
- Latency ack -> `ir_already`: 2 cycles (buffer, then output register).
- Zero-wait memory (ack same cycle as req), no stall: one instruction per cycle sustained.
- N wait cycles: one instruction per N+1 cycles.
- Redirect in cycle T: `ir_already=0` in T+1; first new-path request no earlier than T+1.

## Test plan
- Reset + zero-wait stream, `RESET_PC=0`, `rdata=addr^0xA5A5_0000`: `imem_req` from cycle 0, `ir_already` high every cycle from cycle 2, `pc`=0,4,8,... and `ir` matches.
- 3 wait states: req at 0x0 in cycle 0, ack cycle 3 -> `imem_addr` stable 0x0 cycles 0-3, `ir_already` cycle 5 `pc=0`, next req 0x4 cycle 4.
- Stall 5 cycles with buffer full: `imem_req=0`, `ir_already=0`, `ir`/`pc` hold; after release each address delivered exactly once, none skipped.
- Redirect `redirect_pc=0x103` while WAIT on 0x8 (ack 2 cycles later): req held at 0x8 until ack, word dropped, next req 0x100, first delivered `pc=0x100`; 0x8 never delivered.
- Redirect with stall and buffer full: buffer flushed, `ir_already=0`, fetch of redirect target completes under stall, delivered one cycle after stall drops.
- Reset asserted during WAIT: next cycle `imem_req=0`, `ir_already=0`, after release fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: one-outstanding imem requests, one-entry return buffer,
// registered hand-off to decode with stall and redirect (flush) handling.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_ir,
   output logic [31:0] o_pc,
   output logic        o_ir_already
);

   localparam logic [1:0] S_FETCH   = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_req_addr;
   logic        r_buf_valid;
   logic [31:0] r_buf_ir;
   logic [31:0] r_buf_pc;
   logic [31:0] r_ir;
   logic [31:0] r_pc;
   logic        r_ir_already;

   logic        w_deliver;
   logic        w_room;
   logic        w_accept;
   logic        w_unused_rpc_lo;

   assign w_unused_rpc_lo = &{1'b0, i_redirect_pc[1:0]};

   always_comb begin
      w_deliver   = r_buf_valid & ~i_stall & ~i_redirect;
      w_room      = ~r_buf_valid | w_deliver;
      o_imem_req  = 1'b0;
      o_imem_addr = r_req_addr;
      if (!i_reset) begin
         case (r_state)
            S_FETCH:           o_imem_req = w_room & ~i_redirect;
            S_WAIT, S_DISCARD: o_imem_req = 1'b1;
            default:           o_imem_req = 1'b0;
         endcase
      end
      if (r_state == S_FETCH) o_imem_addr = r_fetch_pc;
      // A word returning on a stale path (DISCARD, or WAIT hit by redirect) is dropped.
      w_accept = o_imem_req & i_imem_ack & ~i_redirect & (r_state != S_DISCARD);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_FETCH;
         r_fetch_pc   <= RESET_PC;
         r_req_addr   <= RESET_PC;
         r_buf_valid  <= 1'b0;
         r_ir         <= 32'h0;
         r_pc         <= 32'h0;
         r_ir_already <= 1'b0;
      end else begin
         r_ir_already <= w_deliver;
         if (w_deliver) begin
            r_ir <= r_buf_ir;
            r_pc <= r_buf_pc;
         end

         if (w_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_ir    <= i_imem_rdata;
            r_buf_pc    <= r_fetch_pc;
         end else if (w_deliver || i_redirect) begin
            r_buf_valid <= 1'b0;
         end

         if (r_state == S_FETCH && o_imem_req) r_req_addr <= r_fetch_pc;

         if (i_redirect)    r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
         else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;

         case (r_state)
            S_FETCH: begin
               if (o_imem_req && !i_imem_ack) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_imem_ack)      r_state <= S_FETCH;
               else if (i_redirect) r_state <= S_DISCARD;
            end
            S_DISCARD: begin
               if (i_imem_ack) r_state <= S_FETCH;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign o_ir         = r_ir;
   assign o_pc         = r_pc;
   assign o_ir_already = r_ir_already;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed streams, a per-cycle vector table, and a randomized
// run against a program-order model of the delivered instruction stream.
module tb_ifetch;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst, stall, redir, ack;
   logic [31:0] rpc, rdata;
   logic        req, ira;
   logic [31:0] addr, ir, pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ifetch #(.RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_redirect(redir),
      .i_redirect_pc(rpc), .o_imem_req(req), .o_imem_addr(addr),
      .i_imem_ack(ack), .i_imem_rdata(rdata), .o_ir(ir), .o_pc(pc),
      .o_ir_already(ira)
   );

   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] rpc;
      logic        ack;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ira;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl[24];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0; ack = 1'b0; rdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // random-phase memory and model state
   logic        busy;
   int          cnt, waitn, ndeliv;
   logic [31:0] laddr, exp_pc, last_pc, last_ir;
   logic        prev_block, prev_rst;

   initial begin
      // ---------- zero-wait stream, then 5-cycle stall with full buffer ----------
      do_reset();
      for (int k = 0; k < 32; k++) begin
         logic        e_ira;
         logic [31:0] e_pc;
         @(negedge clk);
         e_ira = (k >= 2) && !(k >= 17 && k <= 21);
         if (k < 2)        e_pc = 32'h0;
         else if (k <= 16) e_pc = 32'(4 * (k - 2));
         else if (k <= 21) e_pc = 32'h38;
         else              e_pc = 32'h3C + 32'(4 * (k - 22));
         chk("zw_ira", {31'h0, ira}, {31'h0, e_ira});
         chk("zw_pc", pc, e_pc);
         if (e_ira) chk("zw_ir", ir, e_pc ^ KEY);
         rst = 1'b0; redir = 1'b0;
         stall = (k >= 16 && k <= 20);
         #1;
         if (k >= 16 && k <= 20) chk("zw_req_stalled", {31'h0, req}, 32'h0);
         else begin
            chk("zw_req", {31'h0, req}, 32'h1);
            chk("zw_addr", addr, (k < 16) ? 32'(4 * k) : 32'h40 + 32'(4 * (k - 21)));
         end
         ack = req;
         rdata = addr ^ KEY;
      end

      // ---------- per-cycle vector table: wait states, redirects, stall, reset ----------
      tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,  1'b0, 1'b0,32'h0,  1'b0,32'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h0,  1'b0,32'h0};
      tbl[2]  = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h0,  1'b0,32'h0};
      tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h0,  1'b0,32'h0};
      tbl[4]  = '{1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,32'h0,  1'b0,32'h0};
      tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h4,  1'b0,32'h0};
      tbl[6]  = '{1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,32'h4,  1'b1,32'h0};
      tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h8,  1'b0,32'h0};
      tbl[8]  = '{1'b0,1'b0,1'b1,32'h103,1'b0, 1'b1,32'h8,  1'b1,32'h4};
      tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h8,  1'b0,32'h4};
      tbl[10] = '{1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,32'h8,  1'b0,32'h4};
      tbl[11] = '{1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,32'h100,1'b0,32'h4};
      tbl[12] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h104,1'b0,32'h4};
      tbl[13] = '{1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,32'h104,1'b1,32'h100};
      tbl[14] = '{1'b0,1'b1,1'b0,32'h0,  1'b0, 1'b0,32'h0,  1'b0,32'h100};
      tbl[15] = '{1'b0,1'b1,1'b1,32'h200,1'b0, 1'b0,32'h0,  1'b0,32'h100};
      tbl[16] = '{1'b0,1'b1,1'b0,32'h0,  1'b1, 1'b1,32'h200,1'b0,32'h100};
      tbl[17] = '{1'b0,1'b1,1'b0,32'h0,  1'b0, 1'b0,32'h0,  1'b0,32'h100};
      tbl[18] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h204,1'b0,32'h100};
      tbl[19] = '{1'b1,1'b0,1'b0,32'h0,  1'b0, 1'b0,32'h0,  1'b1,32'h200};
      tbl[20] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h0,  1'b0,32'h0};
      tbl[21] = '{1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,32'h0,  1'b0,32'h0};
      tbl[22] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h4,  1'b0,32'h0};
      tbl[23] = '{1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,32'h4,  1'b1,32'h0};
      do_reset();
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk($sformatf("tbl%0d_ira", i), {31'h0, ira}, {31'h0, tbl[i].e_ira});
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
         if (tbl[i].e_ira) chk($sformatf("tbl%0d_ir", i), ir, tbl[i].e_pc ^ KEY);
         rst = tbl[i].rst; stall = tbl[i].stall; redir = tbl[i].redir;
         rpc = tbl[i].rpc; ack = tbl[i].ack;
         #1;
         rdata = addr ^ KEY;
         chk($sformatf("tbl%0d_req", i), {31'h0, req}, {31'h0, tbl[i].e_req});
         if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
      end

      // ---------- randomized run against program-order model ----------
      do_reset();
      busy = 1'b0; cnt = 0; waitn = 0; laddr = 32'h0; ndeliv = 0;
      exp_pc = 32'h0; last_pc = 32'h0; last_ir = 32'h0;
      prev_block = 1'b1; prev_rst = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (prev_rst) begin
            chk("rnd_rst_ira", {31'h0, ira}, 32'h0);
            chk("rnd_rst_pc", pc, 32'h0);
            chk("rnd_rst_ir", ir, 32'h0);
         end else if (prev_block) begin
            chk("rnd_block_ira", {31'h0, ira}, 32'h0);
         end
         if (ira) begin
            chk("rnd_pc", pc, exp_pc);
            chk("rnd_ir", ir, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            ndeliv++;
         end else if (!prev_rst) begin
            chk("rnd_hold_pc", pc, last_pc);
            chk("rnd_hold_ir", ir, last_ir);
         end
         last_pc = pc; last_ir = ir;

         rst   = ($urandom_range(0, 399) == 0);
         stall = ($urandom_range(0, 3) == 0);
         redir = ($urandom_range(0, 31) == 0);
         rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
         if (rst)        exp_pc = 32'h0;
         else if (redir) exp_pc = {rpc[31:2], 2'b00};
         #1;
         ack = 1'b0;
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (busy) chk("rnd_req_held", {31'h0, req}, 32'h1);
            if (req) begin
               if (!busy) begin
                  busy = 1'b1; cnt = 0; waitn = $urandom_range(0, 3); laddr = addr;
               end else begin
                  chk("rnd_addr_stable", addr, laddr);
               end
               if (cnt == waitn) begin
                  ack = 1'b1; busy = 1'b0;
               end else begin
                  cnt++;
               end
            end
         end
         rdata = addr ^ KEY;
         prev_block = rst | stall | redir;
         prev_rst = rst;
      end
      chk("rnd_liveness", {31'h0, (ndeliv >= 200)}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
